// File: rtl/dds_tune_ctrl.sv
// Key-driven tuning controller for a two-channel DDS: debounced push-buttons step frequency and phase words.
// Optional feature: define KEY_AUTOREPEAT_EN to repeat press events while a key is held.
module dds_tune_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [31:0] FWORD_BASE      = 32'd86,
  parameter logic [11:0] PSTEP           = 12'd1024,
  parameter int unsigned REPEAT_CYCLES   = 25_000_000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  Key,
  output logic [31:0] Fword1,
  output logic [31:0] Fword2,
  output logic [11:0] Pword1,
  output logic [11:0] Pword2,
  output logic        Update
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_ONE  = CW'(1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_PRESSED      = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("dds_tune_ctrl: DEBOUNCE_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
  end

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [1:0]    r_state [4];
  logic [CW-1:0] r_cnt   [4];
  logic [3:0]    w_press;
  logic [3:0]    w_evt;

  logic [2:0]    r_idx1;
  logic [2:0]    r_idx2;
  logic [31:0]   r_fword1;
  logic [31:0]   r_fword2;
  logic [11:0]   r_pword2;
  logic          r_update;
  logic [2:0]    w_idx1_nxt;
  logic [2:0]    w_idx2_nxt;

  // The first 0 seen in IDLE counts as sample one of the debounce run.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      for (int unsigned i = 0; i < 4; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_sync1 <= Key;
      r_sync2 <= r_sync1;
      for (int unsigned i = 0; i < 4; i++) begin
        case (r_state[i])
          S_IDLE: begin
            if (!r_sync2[i]) begin
              r_state[i] <= S_PRESS_WAIT;
              r_cnt[i]   <= DB_ONE;
            end
          end
          S_PRESS_WAIT: begin
            if (r_sync2[i]) begin
              r_state[i] <= S_IDLE;
              r_cnt[i]   <= '0;
            end else if (r_cnt[i] == DB_LAST) begin
              r_state[i] <= S_PRESSED;
              r_cnt[i]   <= '0;
            end else begin
              r_cnt[i] <= r_cnt[i] + DB_ONE;
            end
          end
          S_PRESSED: begin
            if (r_sync2[i]) begin
              r_state[i] <= S_RELEASE_WAIT;
              r_cnt[i]   <= DB_ONE;
            end
          end
          default: begin
            if (!r_sync2[i]) begin
              r_state[i] <= S_PRESSED;
              r_cnt[i]   <= '0;
            end else if (r_cnt[i] == DB_LAST) begin
              r_state[i] <= S_IDLE;
              r_cnt[i]   <= '0;
            end else begin
              r_cnt[i] <= r_cnt[i] + DB_ONE;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    w_press = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_press[i] = (r_state[i] == S_PRESS_WAIT) && !r_sync2[i] && (r_cnt[i] == DB_LAST);
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] RP_ONE  = RW'(1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] r_rcnt [4];
  logic [3:0]    w_rep;

  // Repeat phase is anchored to the initial event and frozen during a release bounce.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < 4; i++) r_rcnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_press[i])
          r_rcnt[i] <= '0;
        else if (r_state[i] == S_PRESSED)
          r_rcnt[i] <= (r_rcnt[i] == RP_LAST) ? '0 : r_rcnt[i] + RP_ONE;
        else if (r_state[i] == S_IDLE)
          r_rcnt[i] <= '0;
      end
    end
  end

  always_comb begin
    w_rep = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_rep[i] = (r_state[i] == S_PRESSED) && (r_rcnt[i] == RP_LAST);
    end
    w_evt = w_press | w_rep;
  end
`else
  always_comb begin
    w_evt = w_press;
  end
`endif

  assign w_idx1_nxt = r_idx1 + 3'd1;
  assign w_idx2_nxt = r_idx2 + 3'd1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_idx1   <= '0;
      r_idx2   <= '0;
      r_fword1 <= FWORD_BASE;
      r_fword2 <= FWORD_BASE;
      r_pword2 <= '0;
      r_update <= 1'b0;
    end else begin
      r_update <= |w_evt;
      if (w_evt[3]) begin
        r_idx1   <= '0;
        r_idx2   <= '0;
        r_fword1 <= FWORD_BASE;
        r_fword2 <= FWORD_BASE;
        r_pword2 <= '0;
      end else begin
        if (w_evt[0]) begin
          r_idx1   <= w_idx1_nxt;
          r_fword1 <= FWORD_BASE << w_idx1_nxt;
        end
        if (w_evt[1]) begin
          r_idx2   <= w_idx2_nxt;
          r_fword2 <= FWORD_BASE << w_idx2_nxt;
        end
        if (w_evt[2]) r_pword2 <= r_pword2 + PSTEP;
      end
    end
  end

  assign Fword1 = r_fword1;
  assign Fword2 = r_fword2;
  assign Pword1 = '0;
  assign Pword2 = r_pword2;
  assign Update = r_update;

endmodule

// File: tb/tb_dds_tune_ctrl.sv
// Bench for dds_tune_ctrl: vector table, hand-written corner sequences and random key activity vs a reference model.
module tb_dds_tune_ctrl;

  localparam int D = 250;
  localparam int R = 1000;
  localparam int BASE = 86;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [3:0]  Key;
  logic [31:0] Fword1, Fword2;
  logic [11:0] Pword1, Pword2;
  logic        Update;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  bit chk_en = 0;

  dds_tune_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .FWORD_BASE(32'd86),
    .PSTEP(12'd1024),
    .REPEAT_CYCLES(R)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Key(Key),
    .Fword1(Fword1), .Fword2(Fword2), .Pword1(Pword1), .Pword2(Pword2),
    .Update(Update)
  );

  always #10 Clk = ~Clk;

  // Reference model: per key, a debounced level and the length of the current run
  // of samples disagreeing with it; keys are seen two clocks late.
  bit [3:0] m_d1, m_d2;
  bit       m_pressed [4];
  int       m_run [4];
  int       m_rc [4];
  int       m_idx1, m_idx2, m_p2;
  bit       e_upd;

  function automatic logic [31:0] fw(int idx);
    return 32'(BASE * (2 ** idx));
  endfunction

  function automatic void model_reset();
    m_d1 = '1; m_d2 = '1;
    for (int i = 0; i < 4; i++) begin
      m_pressed[i] = 0; m_run[i] = 0; m_rc[i] = 0;
    end
    m_idx1 = 0; m_idx2 = 0; m_p2 = 0; e_upd = 0;
  endfunction

  function automatic void model_step(bit [3:0] k);
    bit [3:0] s;
    bit [3:0] ev;
    s = m_d2; m_d2 = m_d1; m_d1 = k; ev = '0;
    for (int i = 0; i < 4; i++) begin
`ifdef KEY_AUTOREPEAT_EN
      if (m_pressed[i] && m_run[i] == 0) begin
        if (m_rc[i] == R - 1) begin ev[i] = 1; m_rc[i] = 0; end
        else m_rc[i]++;
      end
`endif
      if (!m_pressed[i]) m_rc[i] = 0;
      if (s[i] == m_pressed[i]) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == D) begin
        m_pressed[i] = !m_pressed[i];
        m_run[i] = 0;
        if (m_pressed[i]) begin ev[i] = 1; m_rc[i] = 0; end
      end
    end
    e_upd = |ev;
    if (ev[3]) begin
      m_idx1 = 0; m_idx2 = 0; m_p2 = 0;
    end else begin
      if (ev[0]) m_idx1 = (m_idx1 + 1) % 8;
      if (ev[1]) m_idx2 = (m_idx2 + 1) % 8;
      if (ev[2]) m_p2 = (m_p2 + 1024) % 4096;
    end
  endfunction

  always @(posedge Clk) begin
    if (Reset) model_reset();
    else model_step(Key);
  end

  always @(negedge Clk) begin
    if (Update) upd_cnt++;
    if (chk_en) begin
      checks++;
      if (Fword1 !== fw(m_idx1) || Fword2 !== fw(m_idx2) || Pword1 !== 12'd0 ||
          Pword2 !== 12'(m_p2) || Update !== e_upd) begin
        errors++;
        $display("FAIL model t=%0t got F1=%0d F2=%0d P1=%0d P2=%0d U=%0b want F1=%0d F2=%0d P1=0 P2=%0d U=%0b",
                 $time, Fword1, Fword2, Pword1, Pword2, Update, fw(m_idx1), fw(m_idx2), m_p2, e_upd);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic hold(input logic [3:0] k, input int n);
    repeat (n) begin
      @(negedge Clk); #2 Key = k;
    end
  endtask

  task automatic pulse_reset(input int n);
    @(negedge Clk); #2 Reset = 1'b1;
    repeat (n) @(negedge Clk);
    #2 Reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  keys;
    logic [31:0] f1;
    logic [31:0] f2;
    logic [11:0] p2;
    int          upd;
  } vec_t;

  vec_t vecs [21];

  initial begin
    vecs[0]  = '{4'hE, 32'd172,   32'd86,  12'd0,    1};
    vecs[1]  = '{4'hD, 32'd172,   32'd172, 12'd0,    1};
    vecs[2]  = '{4'hB, 32'd172,   32'd172, 12'd1024, 1};
    vecs[3]  = '{4'hB, 32'd172,   32'd172, 12'd2048, 1};
    vecs[4]  = '{4'h8, 32'd344,   32'd344, 12'd3072, 1};
    vecs[5]  = '{4'h6, 32'd86,    32'd86,  12'd0,    1};
    vecs[6]  = '{4'h7, 32'd86,    32'd86,  12'd0,    1};
    vecs[7]  = '{4'hE, 32'd172,   32'd86,  12'd0,    1};
    vecs[8]  = '{4'hE, 32'd344,   32'd86,  12'd0,    1};
    vecs[9]  = '{4'hE, 32'd688,   32'd86,  12'd0,    1};
    vecs[10] = '{4'hE, 32'd1376,  32'd86,  12'd0,    1};
    vecs[11] = '{4'hE, 32'd2752,  32'd86,  12'd0,    1};
    vecs[12] = '{4'hE, 32'd5504,  32'd86,  12'd0,    1};
    vecs[13] = '{4'hE, 32'd11008, 32'd86,  12'd0,    1};
    vecs[14] = '{4'hE, 32'd86,    32'd86,  12'd0,    1};
    vecs[15] = '{4'hB, 32'd86,    32'd86,  12'd1024, 1};
    vecs[16] = '{4'hB, 32'd86,    32'd86,  12'd2048, 1};
    vecs[17] = '{4'hB, 32'd86,    32'd86,  12'd3072, 1};
    vecs[18] = '{4'hB, 32'd86,    32'd86,  12'd0,    1};
    vecs[19] = '{4'hB, 32'd86,    32'd86,  12'd1024, 1};
    vecs[20] = '{4'h7, 32'd86,    32'd86,  12'd0,    1};

    Key = '1;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_f1", Fword1, 32'd86);
    chk("rst_f2", Fword2, 32'd86);
    chk("rst_p1", 32'(Pword1), 32'd0);
    chk("rst_p2", 32'(Pword2), 32'd0);
    chk("rst_upd", 32'(Update), 32'd0);
    #2 Reset = 1'b0;
    chk_en = 1;

    upd_cnt = 0;
    hold(4'hF, 300);
    chk("idle_upd", upd_cnt, 0);
    chk("idle_f1", Fword1, 32'd86);
    chk("idle_p2", 32'(Pword2), 32'd0);

    for (int v = 0; v < 21; v++) begin
      upd_cnt = 0;
      hold(vecs[v].keys, 400);
      hold(4'hF, 300);
      chk($sformatf("vec%0d_f1", v), Fword1, vecs[v].f1);
      chk($sformatf("vec%0d_f2", v), Fword2, vecs[v].f2);
      chk($sformatf("vec%0d_p2", v), 32'(Pword2), 32'(vecs[v].p2));
      chk($sformatf("vec%0d_upd", v), upd_cnt, vecs[v].upd);
    end

    // Glitchy Key[1]: low runs of 100 cycles never reach the debounce length.
    upd_cnt = 0;
    repeat (5) begin
      hold(4'hD, 100);
      hold(4'hF, 25);
    end
    chk("glitch_upd", upd_cnt, 0);
    hold(4'hD, 400);
    hold(4'hF, 300);
    chk("glitch_then_stable_upd", upd_cnt, 1);
    chk("glitch_f2", Fword2, 32'd172);

    upd_cnt = 0;
    hold(4'hE, 200);
    hold(4'hF, 300);
    chk("short_press_upd", upd_cnt, 0);

    // Release bounce returns to the held state and must not produce a second event.
    upd_cnt = 0;
    hold(4'hE, 400);
    hold(4'hF, 100);
    hold(4'hE, 50);
    hold(4'hF, 300);
    chk("release_bounce_upd", upd_cnt, 1);
    chk("release_bounce_f1", Fword1, 32'd172);

    hold(4'hE, 200);
    pulse_reset(5);
    upd_cnt = 0;
    hold(4'hE, 100);
    hold(4'hF, 300);
    chk("rst_mid_debounce_upd", upd_cnt, 0);
    chk("rst_mid_debounce_f1", Fword1, 32'd86);

    upd_cnt = 0;
    hold(4'hB, 400);
    chk("hold_p2", 32'(Pword2), 32'd1024);
    pulse_reset(5);
    upd_cnt = 0;
    hold(4'hB, 100);
    hold(4'hF, 300);
    chk("rst_mid_hold_upd", upd_cnt, 0);
    chk("rst_mid_hold_p2", 32'(Pword2), 32'd0);

    upd_cnt = 0;
    hold(4'hE, 1500);
    hold(4'hF, 300);
`ifdef KEY_AUTOREPEAT_EN
    chk("long_hold_upd", upd_cnt, 2);
    chk("long_hold_f1", Fword1, 32'd344);
`else
    chk("long_hold_upd", upd_cnt, 1);
    chk("long_hold_f1", Fword1, 32'd172);
`endif

    for (int s = 0; s < 120; s++) begin
      if ($urandom_range(0, 19) == 0) pulse_reset($urandom_range(1, 4));
      hold(4'($urandom_range(0, 15)), $urandom_range(20, 600));
    end
    hold(4'hF, 300);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
